// File: rtl/alu_lane_sequencer.sv
// Splits one full-warp ALU instruction into NUM_LANES-wide sub-packets tagged with pid/sop/eop,
// skipping sub-packets whose lane mask is empty.
module alu_lane_sequencer #(
  parameter int NUM_THREADS = 16,
  parameter int NUM_LANES   = 4,
  parameter int XLEN        = 32,
  parameter int META_W      = 64,
  localparam int NUM_PKTS   = NUM_THREADS / NUM_LANES,
  localparam int PID_W      = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [META_W-1:0]         in_meta,
  input  logic [NUM_THREADS-1:0]    in_tmask,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs2_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [META_W-1:0]         out_meta,
  output logic [NUM_LANES-1:0]      out_tmask,
  output logic [NUM_LANES*XLEN-1:0] out_rs1_data,
  output logic [NUM_LANES*XLEN-1:0] out_rs2_data,
  output logic [PID_W-1:0]          out_pid,
  output logic                      out_sop,
  output logic                      out_eop
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                    r_state, r_state_next;
  logic [META_W-1:0]         r_meta;
  logic [NUM_THREADS-1:0]    r_tmask;
  logic [NUM_THREADS*XLEN-1:0] r_rs1;
  logic [NUM_THREADS*XLEN-1:0] r_rs2;
  logic [PID_W-1:0]          r_pid, r_pid_next;
  logic                      r_sop, r_sop_next;

  logic [NUM_PKTS-1:0]       w_in_nz;
  logic [NUM_PKTS-1:0]       w_hold_nz;
  logic [PID_W-1:0]          w_first_pid;
  logic [PID_W-1:0]          w_next_pid;
  logic                      w_eop;
  logic                      w_fire;
  logic                      w_accept;
  int                        w_base;

  // Per-slice "has any active lane" flags for the incoming and the held mask.
  for (genvar gi = 0; gi < NUM_PKTS; gi++) begin : g_nz
    assign w_in_nz[gi]   = |in_tmask[gi*NUM_LANES +: NUM_LANES];
    assign w_hold_nz[gi] = |r_tmask[gi*NUM_LANES +: NUM_LANES];
  end

  // Descending scans leave the lowest qualifying index; an all-zero mask falls back to pid 0.
  always_comb begin
    w_first_pid = '0;
    w_next_pid  = r_pid;
    w_eop       = 1'b1;
    for (int k = NUM_PKTS - 1; k >= 0; k--) begin
      if (w_in_nz[k]) begin
        w_first_pid = PID_W'(k);
      end
      if (w_hold_nz[k] && (k > int'(r_pid))) begin
        w_next_pid = PID_W'(k);
        w_eop      = 1'b0;
      end
    end
  end

  assign out_valid = (r_state == S_BUSY);
  assign w_fire    = out_valid & out_ready;
  assign in_ready  = (r_state == S_IDLE) | (w_fire & w_eop);
  assign w_accept  = in_valid & in_ready;

  always_comb begin
    r_state_next = r_state;
    r_pid_next   = r_pid;
    r_sop_next   = r_sop;
    if (w_accept) begin
      r_state_next = S_BUSY;
      r_pid_next   = w_first_pid;
      r_sop_next   = 1'b1;
    end else if (w_fire) begin
      r_sop_next = 1'b0;
      if (w_eop) begin
        r_state_next = S_IDLE;
      end else begin
        r_pid_next = w_next_pid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pid   <= '0;
      r_sop   <= 1'b0;
    end else begin
      r_state <= r_state_next;
      r_pid   <= r_pid_next;
      r_sop   <= r_sop_next;
    end
  end

  // Hold registers need no reset: they are only observed while BUSY.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_meta  <= in_meta;
      r_tmask <= in_tmask;
      r_rs1   <= in_rs1_data;
      r_rs2   <= in_rs2_data;
    end
  end

  assign w_base       = int'(r_pid) * NUM_LANES;
  assign out_meta     = r_meta;
  assign out_tmask    = r_tmask[w_base +: NUM_LANES];
  assign out_rs1_data = r_rs1[w_base*XLEN +: NUM_LANES*XLEN];
  assign out_rs2_data = r_rs2[w_base*XLEN +: NUM_LANES*XLEN];
  assign out_pid      = r_pid;
  assign out_sop      = r_sop;
  assign out_eop      = w_eop;

endmodule

// File: tb/tb_alu_lane_sequencer.sv
// Directed bench for alu_lane_sequencer (16 threads, 4 lanes): table of single instructions
// plus hand-written back-to-back, stall and mid-instruction reset sequences.
module tb_alu_lane_sequencer;

  localparam int NT = 16;
  localparam int NL = 4;
  localparam int XW = 32;
  localparam int MW = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [MW-1:0]   in_meta;
  logic [NT-1:0]   in_tmask;
  logic [NT*XW-1:0] in_rs1_data;
  logic [NT*XW-1:0] in_rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [MW-1:0]   out_meta;
  logic [NL-1:0]   out_tmask;
  logic [NL*XW-1:0] out_rs1_data;
  logic [NL*XW-1:0] out_rs2_data;
  logic [1:0]      out_pid;
  logic            out_sop;
  logic            out_eop;

  int checks = 0;
  int failures = 0;

  alu_lane_sequencer #(.NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XW), .META_W(MW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_meta(in_meta), .in_tmask(in_tmask),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_meta(out_meta), .out_tmask(out_tmask),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_pid(out_pid), .out_sop(out_sop), .out_eop(out_eop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      tmask;
    int               nbeats;
    logic [3:0][1:0]  pids;
    logic [3:0][3:0]  tms;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Lane i of rs1 carries i, lane i of rs2 carries 0x100+i, so slice p holds 4p..4p+3.
  function automatic logic [127:0] exp_slice(input int p, input logic [31:0] base);
    logic [127:0] v;
    v = '0;
    for (int j = 0; j < 4; j++) v[j*32 +: 32] = base + 32'(4*p + j);
    return v;
  endfunction

  task automatic chk_beat(input string tag, input int pid, input logic [3:0] tm,
                          input logic sop, input logic eop, input logic [63:0] meta,
                          input logic exp_in_ready);
    $display("%s: valid=%0b pid=%0d tmask=%h sop=%0b eop=%0b meta=%h in_ready=%0b",
             tag, out_valid, out_pid, out_tmask, out_sop, out_eop, out_meta, in_ready);
    check({tag, " out_valid"}, 128'(out_valid), 128'(1'b1));
    check({tag, " out_pid"},   128'(out_pid),   128'(pid));
    check({tag, " out_tmask"}, 128'(out_tmask), 128'(tm));
    check({tag, " out_sop"},   128'(out_sop),   128'(sop));
    check({tag, " out_eop"},   128'(out_eop),   128'(eop));
    check({tag, " out_meta"},  128'(out_meta),  128'(meta));
    check({tag, " rs1"},       out_rs1_data,    exp_slice(pid, 32'h0));
    check({tag, " rs2"},       out_rs2_data,    exp_slice(pid, 32'h100));
    check({tag, " in_ready"},  128'(in_ready),  128'(exp_in_ready));
  endtask

  task automatic chk_idle(input string tag);
    $display("%s: valid=%0b in_ready=%0b", tag, out_valid, in_ready);
    check({tag, " out_valid"}, 128'(out_valid), 128'(1'b0));
    check({tag, " in_ready"},  128'(in_ready),  128'(1'b1));
  endtask

  task automatic present(input logic [15:0] tm, input logic [63:0] meta);
    in_valid = 1'b1;
    in_tmask = tm;
    in_meta  = meta;
  endtask

  initial begin
    for (int i = 0; i < NT; i++) begin
      in_rs1_data[i*XW +: XW] = 32'(i);
      in_rs2_data[i*XW +: XW] = 32'h100 + 32'(i);
    end
    vecs[0] = '{16'hFFFF, 4, {2'd3, 2'd2, 2'd1, 2'd0}, {4'hF, 4'hF, 4'hF, 4'hF}};
    vecs[1] = '{16'h0F00, 1, {2'd0, 2'd0, 2'd0, 2'd2}, {4'h0, 4'h0, 4'h0, 4'hF}};
    vecs[2] = '{16'h8001, 2, {2'd0, 2'd0, 2'd3, 2'd0}, {4'h0, 4'h0, 4'h8, 4'h1}};
    vecs[3] = '{16'h0000, 1, {2'd0, 2'd0, 2'd0, 2'd0}, {4'h0, 4'h0, 4'h0, 4'h0}};
    vecs[4] = '{16'h0120, 2, {2'd0, 2'd0, 2'd2, 2'd1}, {4'h0, 4'h0, 4'h1, 4'h2}};
    vecs[5] = '{16'hA050, 2, {2'd0, 2'd0, 2'd3, 2'd1}, {4'h0, 4'h0, 4'hA, 4'h5}};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_meta = '0; in_tmask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    $display("reset: valid=%0b in_ready=%0b pid=%0d sop=%0b", out_valid, in_ready, out_pid, out_sop);
    check("reset out_valid", 128'(out_valid), 128'(1'b0));
    check("reset in_ready",  128'(in_ready),  128'(1'b1));
    check("reset out_pid",   128'(out_pid),   128'(2'd0));
    check("reset out_sop",   128'(out_sop),   128'(1'b0));

    // Table-driven single instructions, out_ready held high.
    for (int v = 0; v < 6; v++) begin
      @(negedge clk);
      check($sformatf("vec%0d accept in_ready", v), 128'(in_ready), 128'(1'b1));
      present(vecs[v].tmask, 64'hC0DE_0000_0000_0000 + 64'(v));
      for (int b = 0; b < vecs[v].nbeats; b++) begin
        @(negedge clk);
        in_valid = 1'b0;
        chk_beat($sformatf("vec%0d beat%0d", v, b), int'(vecs[v].pids[b]), vecs[v].tms[b],
                 b == 0, b == vecs[v].nbeats - 1, 64'hC0DE_0000_0000_0000 + 64'(v),
                 b == vecs[v].nbeats - 1);
      end
      @(negedge clk);
      chk_idle($sformatf("vec%0d drained", v));
    end

    // Back-to-back full-mask instructions: eight beats without a bubble.
    @(negedge clk);
    present(16'hFFFF, 64'hAAAA_0000_0000_0001);
    @(negedge clk);
    in_meta = 64'hBBBB_0000_0000_0002;
    for (int b = 0; b < 8; b++) begin
      if (b == 4) begin
        in_valid = 1'b0;
      end
      chk_beat($sformatf("b2b beat%0d", b), b % 4, 4'hF, (b % 4) == 0, (b % 4) == 3,
               (b < 4) ? 64'hAAAA_0000_0000_0001 : 64'hBBBB_0000_0000_0002, (b % 4) == 3);
      @(negedge clk);
    end
    chk_idle("b2b drained");

    // Backpressure while pid 1 is shown: everything must hold.
    @(negedge clk);
    present(16'hFFFF, 64'h5757_0000_0000_0003);
    @(negedge clk);
    in_valid = 1'b0;
    chk_beat("stall beat0", 0, 4'hF, 1'b1, 1'b0, 64'h5757_0000_0000_0003, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    chk_beat("stall pid1 first", 1, 4'hF, 1'b0, 1'b0, 64'h5757_0000_0000_0003, 1'b0);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk_beat($sformatf("stall hold%0d", s), 1, 4'hF, 1'b0, 1'b0, 64'h5757_0000_0000_0003, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_beat("stall beat2", 2, 4'hF, 1'b0, 1'b0, 64'h5757_0000_0000_0003, 1'b0);
    @(negedge clk);
    chk_beat("stall beat3", 3, 4'hF, 1'b0, 1'b1, 64'h5757_0000_0000_0003, 1'b1);
    @(negedge clk);
    chk_idle("stall drained");

    // Reset while pid 2 is shown: pid 3 must never appear.
    @(negedge clk);
    present(16'hFFFF, 64'h7E5E_0000_0000_0004);
    @(negedge clk);
    in_valid = 1'b0;
    chk_beat("rst beat0", 0, 4'hF, 1'b1, 1'b0, 64'h7E5E_0000_0000_0004, 1'b0);
    @(negedge clk);
    chk_beat("rst beat1", 1, 4'hF, 1'b0, 1'b0, 64'h7E5E_0000_0000_0004, 1'b0);
    @(negedge clk);
    chk_beat("rst beat2", 2, 4'hF, 1'b0, 1'b0, 64'h7E5E_0000_0000_0004, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle("rst after");
    check("rst pid cleared", 128'(out_pid), 128'(2'd0));
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk_idle($sformatf("rst quiet%0d", s));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
